// File: rtl/traffic_light_monitor.sv
// Passive checker for a one-hot {R,Y,G} traffic-light bus: tracks phase/dwell, locks on R->G->Y->R.
// Define TLM_DURATION_CHECK_EN to enable SHORT/LONG phase-duration checks.
module traffic_light_monitor #(
  parameter int RED_CYCLES    = 11,
  parameter int GREEN_CYCLES  = 9,
  parameter int YELLOW_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       lights,
  output logic [1:0]       phase,
  output logic             locked,
  output logic [CNT_W-1:0] dwell,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic             cycle_pulse
);

  typedef enum logic [1:0] {
    PH_NONE = 2'b00, PH_RED = 2'b01, PH_GREEN = 2'b10, PH_YELLOW = 2'b11
  } phase_e;

  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_ILLEGAL = 3'd1, E_ORDER = 3'd2, E_SHORT = 3'd3, E_LONG = 3'd4
  } err_e;

`ifdef TLM_DURATION_CHECK_EN
  localparam bit DUR_EN = 1'b1;
`else
  localparam bit DUR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  phase_e           phase_q, phase_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             err_pulse_q, err_pulse_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             cycle_pulse_q, cycle_pulse_d;

  phase_e           color;
  logic             legal_succ;
  logic [CNT_W-1:0] exp_cyc;
  logic [CNT_W-1:0] dwell_inc;
  err_e             err;

  always_comb begin
    unique case (lights)
      3'b100:  color = PH_RED;
      3'b001:  color = PH_GREEN;
      3'b010:  color = PH_YELLOW;
      default: color = PH_NONE;
    endcase
  end

  always_comb begin
    unique case (phase_q)
      PH_RED:   exp_cyc = CNT_W'(RED_CYCLES);
      PH_GREEN: exp_cyc = CNT_W'(GREEN_CYCLES);
      default:  exp_cyc = CNT_W'(YELLOW_CYCLES);
    endcase
  end

  assign legal_succ = (phase_q == PH_RED    && color == PH_GREEN)  ||
                      (phase_q == PH_GREEN  && color == PH_YELLOW) ||
                      (phase_q == PH_YELLOW && color == PH_RED);
  assign dwell_inc  = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + 1'b1;

  always_comb begin
    phase_d       = phase_q;
    locked_d      = locked_q;
    dwell_d       = dwell_q;
    cycle_pulse_d = 1'b0;
    err           = E_NONE;
    if (color == PH_NONE) begin
      err      = E_ILLEGAL;
      phase_d  = PH_NONE;
      dwell_d  = '0;
      locked_d = 1'b0;
    end else if (phase_q == PH_NONE) begin
      phase_d = color;
      dwell_d = 1;
    end else if (color == phase_q) begin
      dwell_d = dwell_inc;
      // Lock drops after LONG, so it cannot refire within the same phase.
      if (DUR_EN && locked_q && dwell_inc == exp_cyc + 1'b1) begin
        err      = E_LONG;
        locked_d = 1'b0;
      end
    end else begin
      phase_d = color;
      dwell_d = 1;
      if (!legal_succ) begin
        err      = E_ORDER;
        locked_d = 1'b0;
      end else if (DUR_EN && locked_q && dwell_q < exp_cyc) begin
        err      = E_SHORT;
        locked_d = 1'b0;
      end else begin
        cycle_pulse_d = locked_q && phase_q == PH_YELLOW;
        locked_d      = 1'b1;
      end
    end
    err_pulse_d = (err != E_NONE);
    err_code_d  = err_pulse_d ? err : err_code_q;
    err_count_d = (err_pulse_d && err_count_q != CNT_MAX) ? err_count_q + 1'b1 : err_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= PH_NONE;
      locked_q      <= 1'b0;
      dwell_q       <= '0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= '0;
      err_count_q   <= '0;
      cycle_pulse_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      locked_q      <= locked_d;
      dwell_q       <= dwell_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      err_count_q   <= err_count_d;
      cycle_pulse_q <= cycle_pulse_d;
    end
  end

  assign phase       = phase_q;
  assign locked      = locked_q;
  assign dwell       = dwell_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign err_count   = err_count_q;
  assign cycle_pulse = cycle_pulse_q;

endmodule
